// File: rtl/multicore_pkg.sv
// Shared defaults and the signed sample type for the multicore sample dispatch path.
package multicore_pkg;

   localparam int unsigned NCORES_DEF     = 24;
   localparam int unsigned DW_DEF         = 31;
   localparam int unsigned FIFO_DEPTH_DEF = 4;

   typedef logic signed [DW_DEF-1:0] sample_t;

   // Index width for a pointer over n entries; never collapses to zero bits.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sample_dispatch_arbiter_if.sv
// ADC ingress and core dispatch signals; master drives samples/requests, slave is the arbiter.
interface sample_dispatch_arbiter_if
   import multicore_pkg::*;
#(
   parameter int unsigned NCORES     = NCORES_DEF,
   parameter int unsigned DW         = DW_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) ();

   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

   logic signed [DW-1:0] adc_data;
   logic                 adc_valid;
   logic                 adc_ready;
   logic [NCORES-1:0]    req;
   logic signed [DW-1:0] core_data;
   logic [NCORES-1:0]    grant;
   logic                 grant_valid;
   logic [LW-1:0]        fifo_level;

   modport master (
      output adc_data, adc_valid, req,
      input  adc_ready, core_data, grant, grant_valid, fifo_level
   );

   modport slave (
      input  adc_data, adc_valid, req,
      output adc_ready, core_data, grant, grant_valid, fifo_level
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after last+1, wrapping at NCORES.
module rr_arbiter
   import multicore_pkg::*;
#(
   parameter int unsigned NCORES = NCORES_DEF,
   parameter int unsigned IW     = idx_width(NCORES_DEF)
) (
   input  logic [NCORES-1:0] req,
   input  logic [IW-1:0]     last,
   output logic [NCORES-1:0] grant_c,
   output logic [IW-1:0]     index_c,
   output logic              any_c
);

   logic [IW-1:0] cand;

   always_comb begin
      grant_c = '0;
      index_c = '0;
      any_c   = 1'b0;
      cand    = '0;
      // Offset i=NCORES revisits last itself, so a lone requester at last still wins.
      for (int unsigned i = 1; i <= NCORES; i++) begin
         cand = IW'((32'(last) + i) % NCORES);
         if (!any_c && req[cand]) begin
            any_c         = 1'b1;
            index_c       = cand;
            grant_c[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sample_dispatch_arbiter.sv
// Buffers ADC samples in a small FIFO and hands the oldest one to a round-robin selected core.
module sample_dispatch_arbiter
   import multicore_pkg::*;
#(
   parameter int unsigned NCORES     = NCORES_DEF,
   parameter int unsigned DW         = DW_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   sample_dispatch_arbiter_if.slave  bus
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned IW = idx_width(NCORES);

   logic signed [DW-1:0] mem_q [FIFO_DEPTH];

   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        level_q, level_d;
   logic [NCORES-1:0]    grant_q, grant_d;
   logic                 grant_valid_q, grant_valid_d;
   logic signed [DW-1:0] core_data_q, core_data_d;
   logic [IW-1:0]        last_q, last_d;

   logic                 push_c;
   logic                 pop_c;
   logic [NCORES-1:0]    arb_grant_c;
   logic [IW-1:0]        arb_index_c;
   logic                 arb_any_c;

   rr_arbiter #(
      .NCORES (NCORES),
      .IW     (IW)
   ) u_rr_arbiter (
      .req     (bus.req),
      .last    (last_q),
      .grant_c (arb_grant_c),
      .index_c (arb_index_c),
      .any_c   (arb_any_c)
   );

   // Ready is combinational so a sample is never accepted into a full buffer.
   assign bus.adc_ready = (level_q < LW'(FIFO_DEPTH)) && !rst;
   assign push_c        = bus.adc_valid && bus.adc_ready;
   // Pop only from what was already registered: a sample pushed this edge is not visible yet.
   assign pop_c         = (level_q != '0) && arb_any_c;

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      level_d       = level_q;
      grant_d       = '0;
      grant_valid_d = 1'b0;
      core_data_d   = core_data_q;
      last_d        = last_q;

      if (push_c) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end

      if (pop_c) begin
         rd_ptr_d      = rd_ptr_q + AW'(1);
         grant_d       = arb_grant_c;
         grant_valid_d = 1'b1;
         core_data_d   = mem_q[rd_ptr_q];
         last_d        = arb_index_c;
      end

      case ({push_c, pop_c})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         core_data_q   <= '0;
         last_q        <= IW'(NCORES - 1);
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         core_data_q   <= core_data_d;
         last_q        <= last_d;
      end
   end

   // Sample storage needs no reset; occupancy is tracked by the pointers and level.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= bus.adc_data;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.core_data   = core_data_q;
   assign bus.fifo_level  = level_q;

endmodule
